// File: rtl/present_pkg.sv
// Shared constants and FSM encoding for the PRESENT core arbiter.
package present_pkg;

  localparam int unsigned BLK_W = 64;
  localparam int unsigned KEY_W = 80;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/present_rr_pick.sv
// Round-robin winner search: first valid requester after last_i, wrapping.
module present_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   winner_o,
  output logic            found_o
);

  logic [IW-1:0] idx;

  // Walk (last+1)..(last+NREQ) mod NREQ; the first hit is the winner.
  always_comb begin
    idx      = '0;
    winner_o = '0;
    found_o  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last_i) + k) % NREQ);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/present_arbiter.sv
// Round-robin scheduler sharing one PRESENT cipher core between NREQ requesters,
// with a watchdog that converts a hung core into an error response.
module present_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BLK_W   = present_pkg::BLK_W,
  parameter int unsigned KEY_W   = present_pkg::KEY_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    iReset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BLK_W-1:0]   req_data,
  input  logic [NREQ*KEY_W-1:0]   req_key,
  input  logic [NREQ-1:0]         req_mode,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [BLK_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    core_load,
  output logic [BLK_W-1:0]        core_idat,
  output logic [KEY_W-1:0]        core_key,
  output logic                    core_control,
  input  logic                    core_done,
  input  logic [BLK_W-1:0]        core_odat
);

  import present_pkg::*;

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BLK_W-1:0]  data_q, data_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              mode_q, mode_d;
  logic [BLK_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              core_load_q, core_load_d;
  logic [NREQ-1:0]   req_ready_c;
  logic [IW-1:0]     winner;
  logic              found;

  present_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (winner),
    .found_o  (found)
  );

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NREQ - 1);
      timer_q     <= '0;
      data_q      <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      core_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      core_load_q <= core_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    timer_d     = timer_q;
    data_d      = data_q;
    key_d       = key_q;
    mode_d      = mode_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    core_load_d = 1'b0;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[winner] = 1'b1;
          data_d      = req_data[32'(winner) * BLK_W +: BLK_W];
          key_d       = req_key[32'(winner) * KEY_W +: KEY_W];
          mode_d      = req_mode[winner];
          owner_d     = winner;
          core_load_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        timer_d = '0;
        state_d = WAIT;
      end
      // timer_q == 0 marks the first WAIT cycle, where done may be stale.
      WAIT: begin
        if (core_done && (timer_q != '0)) begin
          rsp_data_d  = core_odat;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          state_d     = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NREQ'(1) << owner_q;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_d      = owner_q;
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready    = req_ready_c;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign core_load    = core_load_q;
  assign core_idat    = data_q;
  assign core_key     = key_q;
  assign core_control = mode_q;

endmodule

// File: tb/tb_present_arbiter.sv
// Directed bench for present_arbiter with a lookup-table PRESENT core model.
module tb_present_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned BLK_W   = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned TIMEOUT = 16;
  localparam int          LAT     = 6;

  localparam logic [63:0] CT_K0   = 64'h5579C1387B228445;
  localparam logic [63:0] CT_KF   = 64'hE72C46C0F5945049;
  localparam logic [79:0] KEY_F   = {80{1'b1}};

  logic                  clk = 1'b0;
  logic                  iReset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*BLK_W-1:0] req_data;
  logic [NREQ*KEY_W-1:0] req_key;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [BLK_W-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  core_load;
  logic [BLK_W-1:0]      core_idat;
  logic [KEY_W-1:0]      core_key;
  logic                  core_control;
  logic                  core_done;
  logic [BLK_W-1:0]      core_odat;

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;

  present_arbiter #(
    .NREQ(NREQ), .BLK_W(BLK_W), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .iReset(iReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_key(req_key), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_load(core_load), .core_idat(core_idat), .core_key(core_key),
    .core_control(core_control), .core_done(core_done), .core_odat(core_odat)
  );

  always #5 clk = ~clk;

  // Core model: known PRESENT-80 vectors, fixed latency, optional hang.
  logic        busy = 1'b0;
  int          cnt = 0;
  logic        done_q = 1'b0;
  logic [63:0] res_q = '0;
  logic [63:0] odat_q = '0;
  logic        hang = 1'b0;
  logic        stray = 1'b0;

  function automatic logic [63:0] cipher_lut(input logic [63:0] d, input logic [79:0] k,
                                             input logic m);
    if (!m && d == 64'h0 && k == 80'h0) return CT_K0;
    if (!m && d == 64'h0 && k == KEY_F) return CT_KF;
    if (m && d == CT_K0 && k == 80'h0) return 64'h0;
    return 64'hBAD0BAD0BAD0BAD0;
  endfunction

  always @(posedge clk) begin
    done_q <= 1'b0;
    if (core_load) begin
      load_cnt <= load_cnt + 1;
      busy     <= 1'b1;
      cnt      <= LAT - 1;
      res_q    <= cipher_lut(core_idat, core_key, core_control);
    end else if (busy) begin
      if (cnt == 0) begin
        busy <= 1'b0;
        if (!hang) begin
          done_q <= 1'b1;
          odat_q <= res_q;
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  assign core_done = done_q | stray;
  assign core_odat = stray ? 64'hDEADDEADDEADDEAD : odat_q;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present a request, check the grant, then check the LOAD pulse and its payload.
  task automatic issue(input int idx, input logic [63:0] d, input logic [79:0] k,
                       input logic m, input bit keep, input string tag);
    req_data[idx*BLK_W +: BLK_W] = d;
    req_key[idx*KEY_W +: KEY_W]  = k;
    req_mode[idx]  = m;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 100 && req_ready == '0; c++) @(negedge clk);
    check({tag, "_grant"}, 80'(req_ready), 80'(1) << idx);
    @(posedge clk); #1;
    if (!keep) req_valid[idx] = 1'b0;
    @(negedge clk);
    check({tag, "_load"}, 80'(core_load), 80'(1));
    check({tag, "_idat"}, 80'(core_idat), 80'(d));
    check({tag, "_key"}, core_key, k);
    check({tag, "_ctl"}, 80'(core_control), 80'(m));
    @(negedge clk);
    check({tag, "_load1"}, 80'(core_load), 80'(0));
  endtask

  // Wait for the response, optionally stall it for 'hold' cycles, then accept.
  task automatic collect(input int idx, input logic [63:0] d, input logic e,
                         input int hold, input string tag);
    @(negedge clk);
    for (int c = 0; c < 200 && rsp_valid == '0; c++) @(negedge clk);
    check({tag, "_rv"}, 80'(rsp_valid), 80'(1) << idx);
    check({tag, "_data"}, 80'(rsp_data), 80'(d));
    check({tag, "_err"}, 80'(rsp_err), 80'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_rv"}, 80'(rsp_valid), 80'(1) << idx);
      check({tag, "_hold_data"}, 80'(rsp_data), 80'(d));
      check({tag, "_hold_rdy"}, 80'(req_ready), 80'(0));
    end
    @(posedge clk); #1;
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    check({tag, "_acc_rdy"}, 80'(req_ready), 80'(0));
    @(posedge clk); #1;
    rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    iReset    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_key   = '0;
    req_mode  = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 iReset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 80'(req_ready), 80'(0));
    check("rst_rsp_valid", 80'(rsp_valid), 80'(0));
    check("rst_core_load", 80'(core_load), 80'(0));
    check("rst_core_idat", 80'(core_idat), 80'(0));
    check("rst_core_key", core_key, 80'(0));
    check("rst_rsp", {15'(0), rsp_err, rsp_data}, 80'(0));
    @(posedge clk); #1;

    // Single encrypt on requester 0
    issue(0, 64'h0, 80'h0, 1'b0, 1'b0, "enc0");
    collect(0, CT_K0, 1'b0, 0, "enc0");
    check("enc0_load_count", 80'(load_cnt), 80'(1));

    // Decrypt on requester 1; a stale done in the first WAIT cycle must be ignored
    issue(1, CT_K0, 80'h0, 1'b1, 1'b0, "dec1");
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    collect(1, 64'h0, 1'b0, 0, "dec1");
    check("dec1_ctl_held", 80'(core_control), 80'(1));

    // Both requesters continuously valid: strict alternation starting at 0
    req_valid = 2'b11;
    for (int op = 0; op < 8; op++) begin
      issue(op % 2, 64'h0, KEY_F, 1'b0, op < 6, $sformatf("rr%0d", op));
      collect(op % 2, CT_KF, 1'b0, 0, $sformatf("rr%0d", op));
    end

    // Response stalled 10 cycles while requester 1 waits
    issue(0, 64'h0, 80'h0, 1'b0, 1'b0, "stall0");
    req_data[BLK_W +: BLK_W] = 64'h0;
    req_key[KEY_W +: KEY_W]  = KEY_F;
    req_mode[1]  = 1'b0;
    req_valid[1] = 1'b1;
    collect(0, CT_K0, 1'b0, 10, "stall0");
    issue(1, 64'h0, KEY_F, 1'b0, 1'b0, "stall1");
    collect(1, CT_KF, 1'b0, 0, "stall1");

    // Hung core: error response exactly TIMEOUT cycles after WAIT entry
    hang = 1'b1;
    issue(0, 64'h0, 80'h0, 1'b0, 1'b0, "to0");
    repeat (TIMEOUT - 1) @(negedge clk);
    check("to0_early", 80'(rsp_valid), 80'(0));
    @(negedge clk);
    check("to0_edge_rv", 80'(rsp_valid), 80'(1));
    check("to0_edge_err", 80'(rsp_err), 80'(1));
    collect(0, 64'h0, 1'b1, 0, "to0");
    hang = 1'b0;
    issue(1, 64'h0, 80'h0, 1'b0, 1'b0, "after_to");
    collect(1, CT_K0, 1'b0, 0, "after_to");

    // Reset in WAIT after requester 0 was last served; stray done follows
    issue(0, 64'h0, KEY_F, 1'b0, 1'b0, "pre_rst");
    collect(0, CT_KF, 1'b0, 0, "pre_rst");
    issue(1, CT_K0, 80'h0, 1'b1, 1'b0, "mid_rst");
    @(posedge clk); #1;
    iReset = 1'b1;
    @(posedge clk); #1;
    iReset = 1'b0;
    @(negedge clk);
    check("mrst_rsp_valid", 80'(rsp_valid), 80'(0));
    check("mrst_core_load", 80'(core_load), 80'(0));
    check("mrst_core_idat", 80'(core_idat), 80'(0));
    check("mrst_core_key", core_key, 80'(0));
    check("mrst_ctl", 80'(core_control), 80'(0));
    check("mrst_rsp", {15'(0), rsp_err, rsp_data}, 80'(0));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("mrst_stray_rv", 80'(rsp_valid), 80'(0));
      check("mrst_stray_load", 80'(core_load), 80'(0));
    end
    @(posedge clk); #1;
    req_data[BLK_W +: BLK_W] = CT_K0;
    req_key[KEY_W +: KEY_W]  = 80'h0;
    req_mode[1]  = 1'b1;
    req_valid    = 2'b11;
    issue(0, 64'h0, 80'h0, 1'b0, 1'b0, "post_rst0");
    collect(0, CT_K0, 1'b0, 0, "post_rst0");
    issue(1, CT_K0, 80'h0, 1'b1, 1'b0, "post_rst1");
    collect(1, 64'h0, 1'b0, 0, "post_rst1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/present_arbiter.md
Name: present_arbiter

Overview:
- Round-robin scheduler that shares one PRESENT_CORE-style cipher engine between NREQ independent requesters.
- Each requester submits a block, key and mode through a valid/ready request channel.
- The arbiter sequences the core: one-cycle load, wait for done, capture the result, return it on a per-requester valid/ready response channel.
- A watchdog turns a hung core into an error response.
- Sits between bus-side crypto clients (e.g. peripheral wrappers) and the single shared core instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- BLK_W, 64, cipher block width.
- KEY_W, 80, key width.
- TIMEOUT, 64, max cycles in WAIT before error; must exceed core latency.

Ports:
- clk  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle; one-hot or zero.
- req_data  in  NREQ*BLK_W  input blocks; requester i at [i*BLK_W +: BLK_W].
- req_key  in  NREQ*KEY_W  keys; requester i at [i*KEY_W +: KEY_W].
- req_mode  in  NREQ  0 = encrypt, 1 = decrypt.
- rsp_valid  out  NREQ  response valid, one-hot or zero.
- rsp_ready  in  NREQ  requester accepts response.
- rsp_data  out  BLK_W  result block (shared bus).
- rsp_err  out  1  response is a timeout error; qualified by rsp_valid.
- core_load  out  1  one-cycle load pulse to core.
- core_idat  out  BLK_W  block to core.
- core_key  out  KEY_W  key to core.
- core_control  out  1  core mode, 0 = encrypt, 1 = decrypt.
- core_done  in  1  core result-ready pulse.
- core_odat  in  BLK_W  core result, valid when core_done = 1.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state = IDLE, last_grant = NREQ-1 so requester 0 wins first.
  - All outputs 0; timer 0; captured data, key and result registers 0.
  - An in-flight core operation is abandoned; its later core_done is ignored.
- IDLE:
  - Winner = first i with req_valid[i], searching (last_grant+1) mod NREQ upward with wrap.
  - If a winner exists: req_ready[winner] = 1 combinationally this cycle; register req_data, req_key and req_mode slices plus owner = winner; next state LOAD.
  - No req_valid set: stay in IDLE.
  - Requester obligation: keep valid and payload stable until ready.
- LOAD:
  - core_load = 1 for exactly one cycle.
  - core_idat, core_key and core_control driven from the captured registers; held stable in every state until the next capture.
  - Next state WAIT, timer = 0.
- WAIT:
  - core_done is ignored in the first WAIT cycle, because the core's done is registered and may reflect pre-load state.
  - From the second WAIT cycle, core_done = 1: capture core_odat into rsp_data, rsp_err = 0, next state RESP.
  - Otherwise timer increments. When timer == TIMEOUT-1 with no done: rsp_data = 0, rsp_err = 1, next state RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid[owner] = 1; rsp_data and rsp_err held until accepted.
  - On rsp_ready[owner]: last_grant = owner, next state IDLE. No new grant in the same cycle.
  - rsp_ready of non-owners is ignored.
- core_done outside WAIT is ignored.
- Minimum issue interval is 3 cycles plus core latency plus 1.
- Request accepted at cycle T gives core_load at T+1, WAIT from T+2, and rsp_valid the cycle after core_done is seen.
- Fairness: a continuously requesting set is served strictly in rotation. A requester is never served twice while another was valid at both of its grant points.
- Invariants:
  - req_ready is asserted only in IDLE; rsp_valid only in RESP.
  - Both are one-hot or zero.

Decomposition:
- Shared package present_pkg:
  - BLK_W and KEY_W constants.
  - MODE_ENC = 0, MODE_DEC = 1.
  - FSM state encoding: IDLE, LOAD, WAIT, RESP (2 bits).
- One natural sub-module: present_rr_pick.
  - Inputs: NREQ request vector, last_grant.
  - Outputs: winner index and found flag.
  - Purely combinational rotate, priority-encode, un-rotate.
- Top instantiates present_rr_pick, the FSM, and the capture registers. The core itself is instantiated outside.

Test Plan:
- Req0 encrypt, data 0, key 0 -> rsp_valid[0], rsp_data = 5579C1387B228445, rsp_err = 0; core_load is exactly one pulse at T+1.
- Req1 decrypt, data 5579C1387B228445, key 0 -> rsp_valid[1], rsp_data = 0000000000000000, core_control = 1 throughout.
- Req0 and req1 both held valid for 4 ops each (key FFFFFFFFFFFFFFFFFFFF, data 0, encrypt) -> grant order 0,1,0,1,0,1,0,1; every result = E72C46C0F5945049.
- rsp_ready[0] held low 10 cycles while req1 valid -> rsp_valid[0] and rsp_data stable all 10 cycles, req_ready[1] stays 0; req1 granted only after acceptance.
- Core model never asserts done -> rsp_err = 1 and rsp_data = 0 exactly TIMEOUT cycles after WAIT entry; the next request is then served normally.
- iReset pulsed during WAIT, core_done arriving 5 cycles later -> all outputs 0 after reset, stray done ignored, next grant goes to requester 0.
